// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
// Holds the bridge state encoding and the alignment helper.
package dmem_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 64;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_PEND = 3'd1,
        LD_REQ  = 3'd2,
        LD_WAIT = 3'd3,
        LD_DONE = 3'd4
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_bridge_timeout.sv
// Wait-cycle counter for the bus bridge.
// Flags expiry once TIMEOUT_CYC-1 cycles have been counted.
module bus_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: clear on state change, saturate at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Core data-memory port to handshaked bus bridge.
// One posted store slot, stalling loads, timeout and sticky error.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_en,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              tmo_en;
    logic              tmo_clr;
    logic              tmo_expired;
    logic [DATA_W-1:0] core_addr_al;

    assign core_addr_al = {core_addr[DATA_W-1:2], 2'b00};

    assign tmo_en  = (state_q == ST_PEND) ||
                     (state_q == LD_REQ)  ||
                     (state_q == LD_WAIT);
    assign tmo_clr = (state_d != state_q);

    bus_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    // Bus side is driven only from state and capture registers.
    assign bus_req    = (state_q == ST_PEND) || (state_q == LD_REQ);
    assign bus_we     = (state_q == ST_PEND);
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign core_rdata = rdata_q;
    assign err        = err_q;

    // Next-state, capture and stall decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        core_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (core_en) begin
                    if (is_misaligned(core_addr[1:0])) begin
                        err_d = 1'b1;
                        if (!core_we) begin
                            core_stall = 1'b1;
                            rdata_d    = '0;
                            state_d    = LD_DONE;
                        end
                    end else if (core_we) begin
                        addr_d  = core_addr_al;
                        wdata_d = core_wdata;
                        state_d = ST_PEND;
                    end else begin
                        core_stall = 1'b1;
                        addr_d     = core_addr_al;
                        state_d    = LD_REQ;
                    end
                end
            end
            ST_PEND: begin
                core_stall = core_en;
                if (bus_ready) begin
                    state_d = IDLE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LD_REQ: begin
                core_stall = 1'b1;
                if (bus_ready) begin
                    state_d = LD_WAIT;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = LD_DONE;
                end
            end
            LD_WAIT: begin
                core_stall = 1'b1;
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    state_d = LD_DONE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = LD_DONE;
                end
            end
            LD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_dmem_bridge;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_en;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_bridge #(
        .DATA_W     (32),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_en   (core_en),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata),
        .err       (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st;
        return 32'(dut.state_q);
    endfunction

    initial begin
        rst        = 1'b1;
        core_en    = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        tick();
        tick();
        #1;
        chk("rst_state", st(), 32'(IDLE));
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(core_stall), 32'd0);
        rst = 1'b0;

        // Posted store, slave ready on the third request cycle
        tick();
        core_en    = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h10;
        core_wdata = 32'hA5A5_0001;
        #1;
        chk("st_idle_stall", 32'(core_stall), 32'd0);
        tick();
        core_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus_ready = 1'b1;
            #1;
            chk("st_stall", 32'(core_stall), 32'd0);
            chk("st_req", 32'(bus_req), 32'd1);
            chk("st_we", 32'(bus_we), 32'd1);
            chk("st_addr", bus_addr, 32'h10);
            chk("st_wdata", bus_wdata, 32'hA5A5_0001);
            tick();
        end
        bus_ready = 1'b0;
        #1;
        chk("st_back_idle", st(), 32'(IDLE));
        chk("st_req_low", 32'(bus_req), 32'd0);

        // Load, fastest slave: 3 stall cycles
        tick();
        core_en   = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h20;
        #1;
        chk("ld_stall_c1", 32'(core_stall), 32'd1);
        chk("ld_noreq_c1", 32'(bus_req), 32'd0);
        tick();
        bus_ready = 1'b1;
        #1;
        chk("ld_stall_c2", 32'(core_stall), 32'd1);
        chk("ld_req", 32'(bus_req), 32'd1);
        chk("ld_we", 32'(bus_we), 32'd0);
        chk("ld_addr", bus_addr, 32'h20);
        tick();
        bus_ready  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1234_5678;
        #1;
        chk("ld_stall_c3", 32'(core_stall), 32'd1);
        chk("ld_wait_noreq", 32'(bus_req), 32'd0);
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        #1;
        chk("ld_done_stall", 32'(core_stall), 32'd0);
        chk("ld_done_rdata", core_rdata, 32'h1234_5678);
        chk("ld_done_noreq", 32'(bus_req), 32'd0);
        chk("ld_done_state", st(), 32'(LD_DONE));
        tick();
        core_en = 1'b0;
        #1;
        chk("ld_idle_noreq", 32'(bus_req), 32'd0);
        chk("ld_rdata_hold", core_rdata, 32'h1234_5678);

        // Store 0x30 then load 0x30, slave ready after 4 cycles
        tick();
        core_en    = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h30;
        core_wdata = 32'hCAFE_0030;
        #1;
        chk("sl_st_stall", 32'(core_stall), 32'd0);
        tick();
        core_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_ready = 1'b1;
            #1;
            chk("sl_pend_stall", 32'(core_stall), 32'd1);
            chk("sl_pend_we", 32'(bus_we), 32'd1);
            tick();
        end
        bus_ready = 1'b0;
        #1;
        chk("sl_gap_req", 32'(bus_req), 32'd0);
        chk("sl_gap_stall", 32'(core_stall), 32'd1);
        chk("sl_gap_state", st(), 32'(IDLE));
        tick();
        bus_ready = 1'b1;
        #1;
        chk("sl_ld_req", 32'(bus_req), 32'd1);
        chk("sl_ld_we", 32'(bus_we), 32'd0);
        chk("sl_ld_addr", bus_addr, 32'h30);
        tick();
        bus_ready  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_0030;
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("sl_rdata", core_rdata, 32'hDEAD_0030);
        chk("sl_done_stall", 32'(core_stall), 32'd0);
        tick();
        core_en = 1'b0;

        // Load timeout in LD_WAIT with TIMEOUT_CYC=8
        tick();
        core_en   = 1'b1;
        core_addr = 32'h40;
        tick();
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to_wait_state", st(), 32'(LD_WAIT));
            chk("to_wait_err", 32'(err), 32'd0);
            chk("to_wait_stall", 32'(core_stall), 32'd1);
            tick();
        end
        #1;
        chk("to_done_state", st(), 32'(LD_DONE));
        chk("to_err", 32'(err), 32'd1);
        chk("to_rdata", core_rdata, 32'd0);
        chk("to_stall", 32'(core_stall), 32'd0);
        tick();
        core_en = 1'b0;

        // Reset during LD_WAIT
        tick();
        core_en   = 1'b1;
        core_addr = 32'h50;
        tick();
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        #1;
        chk("rw_state", st(), 32'(LD_WAIT));
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        core_en = 1'b0;
        #1;
        chk("rw_idle", st(), 32'(IDLE));
        chk("rw_req", 32'(bus_req), 32'd0);
        chk("rw_stall", 32'(core_stall), 32'd0);
        chk("rw_err", 32'(err), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("rw_late_rdata", core_rdata, 32'd0);
        chk("rw_late_state", st(), 32'(IDLE));

        // Good load to make rdata non-zero
        core_en   = 1'b1;
        core_addr = 32'h60;
        tick();
        bus_ready = 1'b1;
        tick();
        bus_ready  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h55AA_55AA;
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("pre_rdata", core_rdata, 32'h55AA_55AA);
        tick();
        core_en = 1'b0;

        // Misaligned load
        tick();
        core_en   = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h22;
        #1;
        chk("mis_ld_stall", 32'(core_stall), 32'd1);
        chk("mis_ld_req0", 32'(bus_req), 32'd0);
        tick();
        #1;
        chk("mis_ld_state", st(), 32'(LD_DONE));
        chk("mis_ld_err", 32'(err), 32'd1);
        chk("mis_ld_rdata", core_rdata, 32'd0);
        chk("mis_ld_req1", 32'(bus_req), 32'd0);
        chk("mis_ld_stall2", 32'(core_stall), 32'd0);
        tick();
        core_en = 1'b0;

        // Misaligned store is dropped
        tick();
        core_en    = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h33;
        core_wdata = 32'h0BAD_0BAD;
        #1;
        chk("mis_st_stall", 32'(core_stall), 32'd0);
        tick();
        core_en = 1'b0;
        #1;
        chk("mis_st_state", st(), 32'(IDLE));
        chk("mis_st_req", 32'(bus_req), 32'd0);
        chk("mis_st_err", 32'(err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
